div_ctrl: RTL and testbench

Issue-side controller for the iterative 32-bit radix-2 divider in the execute stage. It accepts DIV/DIVU requests from the pipeline, registers the operands, and drives the divider's `div`/`div_signed`/`x`/`y` inputs. It waits for the divider's `complete`, then writes quotient to LO and remainder to HI, and enforces the divider's required idle gap between operations. It also owns the HI/LO registers and their direct-write port (MTHI/MTLO), and stalls issue while a divide is in flight.

---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/hilo_reg.sv | 29 ++
 rtl/div_ctrl.sv | 103 ++++++++++
 tb/tb_div_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue controller: FSM encoding,
// watchdog counter width and the default watchdog limit.
package div_ctrl_pkg;

  localparam int WD_W        = 6;
  localparam int TIMEOUT_DEF = 40;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO registers. Two write sources: a divide result
// capture and the MTHI/MTLO direct port. Capture wins per register.
module hilo_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic [31:0] cap_hi,
  input  logic [31:0] cap_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI/LO update: capture has priority over the direct write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (cap_en)     hi <= cap_hi;
      else if (hi_we) hi <= wdata;
      if (cap_en)     lo <= cap_lo;
      else if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Issue-side controller for the iterative radix-2 divider.
//
//   state | meaning
//   IDLE  | ready for a DIV/DIVU request
//   RUN   | div held high, waiting for div_complete (watchdog running)
//   GAP   | div low for one edge so the divider sees the end of the op
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        div_clk,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        op_signed,
  input  logic [31:0] src_x,
  input  logic [31:0] src_y,
  input  logic        flush,
  output logic        div,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        result_valid,
  output logic        timeout_err
);

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              in_run;
  logic              accept;
  logic              capture;
  logic              wd_hit;
  logic              abort;

  assign in_run  = (state == ST_RUN);
  assign accept  = issue_valid && (state == ST_IDLE) && !flush;
  // flush beats a completing divide; a completion beats a coincident watchdog hit
  assign capture = in_run && !flush && div_complete;
  assign wd_hit  = in_run && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign abort   = wd_hit && !flush && !div_complete;

  assign div         = in_run;
  assign busy        = (state != ST_IDLE);
  assign issue_ready = (state == ST_IDLE);

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (flush || div_complete || wd_hit) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state, operand latch, watchdog and status flags
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      wd_cnt       <= '0;
      div_x        <= '0;
      div_y        <= '0;
      div_signed   <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      result_valid <= capture;
      if (abort) timeout_err <= 1'b1;
      if (accept) begin
        div_x      <= src_x;
        div_y      <= src_y;
        div_signed <= op_signed;
        wd_cnt     <= '0;
      end else if (in_run) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  hilo_reg u_hilo (
    .clk    (div_clk),
    .rst_n  (resetn),
    .cap_en (capture),
    .cap_hi (div_r),
    .cap_lo (div_s),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (hilo_wdata),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl. The divider is emulated by tasks that raise
// div_complete a fixed latency after div goes high. Expected HI/LO
// pairs are queued at issue and popped when result_valid appears.
module tb_div_ctrl;

  localparam int LAT = 34;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        issue_valid, op_signed, flush, div_complete, hi_we, lo_we;
  logic [31:0] src_x, src_y, div_s, div_r, hilo_wdata;
  logic        issue_ready, div, div_signed, busy, result_valid, timeout_err;
  logic [31:0] div_x, div_y, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 div_clk = ~div_clk;

  div_ctrl #(.TIMEOUT(40)) dut (
    .div_clk      (div_clk),
    .resetn       (resetn),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .op_signed    (op_signed),
    .src_x        (src_x),
    .src_y        (src_y),
    .flush        (flush),
    .div          (div),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hilo_wdata   (hilo_wdata),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .result_valid (result_valid),
    .timeout_err  (timeout_err)
  );

  // Stand-in for the divider datapath (truncating division, remainder takes dividend sign)
  function automatic exp_t divide(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    exp_t o;
    if (sgn) begin
      o.lo = 32'($signed(x) / $signed(y));
      o.hi = 32'($signed(x) % $signed(y));
    end else begin
      o.lo = x / y;
      o.hi = x % y;
    end
    return o;
  endfunction

  task automatic pop_compare(input string nm);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_sb: got result with empty scoreboard, required a queued entry", nm);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (hi !== e.hi || lo !== e.lo) begin
        miscompares++;
        $display("FAIL %s_hilo: got hi=%h lo=%h, required hi=%h lo=%h", nm, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  // One full operation with the emulated divider; expected result already queued
  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y, input string nm);
    exp_t d;
    @(negedge div_clk);
    issue_valid = 1'b1; op_signed = sgn; src_x = x; src_y = y;
    @(negedge div_clk);
    issue_valid = 1'b0;
    vectors++;
    if (div !== 1'b1 || div_x !== x || div_y !== y || div_signed !== sgn || issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_accept: got div=%b x=%h y=%h sgn=%b rdy=%b, required 1 %h %h %b 0",
               nm, div, div_x, div_y, div_signed, issue_ready, x, y, sgn);
    end
    repeat (LAT - 1) @(negedge div_clk);
    d = divide(div_signed, div_x, div_y);
    div_s = d.lo; div_r = d.hi; div_complete = 1'b1;
    @(negedge div_clk);
    div_complete = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || div !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_capture: got rv=%b div=%b busy=%b, required 1 0 1", nm, result_valid, div, busy);
    end
    pop_compare(nm);
    @(negedge div_clk);
    vectors++;
    if (result_valid !== 1'b0 || div !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_gap: got rv=%b div=%b busy=%b rdy=%b, required 0 0 0 1",
               nm, result_valid, div, busy, issue_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; issue_valid = 0; op_signed = 0; flush = 0; div_complete = 0;
    hi_we = 0; lo_we = 0; src_x = 0; src_y = 0; div_s = 0; div_r = 0; hilo_wdata = 0;
    repeat (2) @(negedge div_clk);
    resetn = 1'b1;
    @(negedge div_clk);
    vectors++;
    if (div !== 0 || div_signed !== 0 || busy !== 0 || result_valid !== 0 || timeout_err !== 0 || issue_ready !== 1) begin
      miscompares++;
      $display("FAIL reset_ctl: got div=%b sgn=%b busy=%b rv=%b to=%b rdy=%b, required 0 0 0 0 0 1",
               div, div_signed, busy, result_valid, timeout_err, issue_ready);
    end
    vectors++;
    if (div_x !== 0 || div_y !== 0 || hi !== 0 || lo !== 0) begin
      miscompares++;
      $display("FAIL reset_data: got x=%h y=%h hi=%h lo=%h, required all 0", div_x, div_y, hi, lo);
    end
  endtask

  task automatic test_divu();
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
    sb.push_back('{hi: 32'h0000000F, lo: 32'h0FFFFFFF});
    run_op(1'b0, 32'hFFFFFFFF, 32'd16, "divu_max_16");
  endtask

  task automatic test_div();
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
  endtask

  task automatic test_back_to_back();
    exp_t d;
    @(negedge div_clk);
    issue_valid = 1'b1; op_signed = 1'b0; src_x = 32'd100; src_y = 32'd7;
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    sb.push_back('{hi: 32'h0000000F, lo: 32'h0FFFFFFF});
    @(negedge div_clk);
    src_x = 32'hFFFFFFFF; src_y = 32'd16;
    vectors++;
    if (div !== 1'b1 || div_x !== 32'd100) begin
      miscompares++;
      $display("FAIL b2b_first: got div=%b x=%h, required 1 00000064", div, div_x);
    end
    repeat (LAT - 1) @(negedge div_clk);
    vectors++;
    if (issue_ready !== 1'b0 || div_x !== 32'd100) begin
      miscompares++;
      $display("FAIL b2b_run_hold: got rdy=%b x=%h, required 0 00000064", issue_ready, div_x);
    end
    d = divide(div_signed, div_x, div_y);
    div_s = d.lo; div_r = d.hi; div_complete = 1'b1;
    @(negedge div_clk);
    div_complete = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || issue_ready !== 1'b0 || div !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap: got rv=%b rdy=%b div=%b, required 1 0 0", result_valid, issue_ready, div);
    end
    pop_compare("b2b_first");
    @(negedge div_clk);
    vectors++;
    if (issue_ready !== 1'b1 || div !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got rdy=%b div=%b, required 1 0", issue_ready, div);
    end
    @(negedge div_clk);
    issue_valid = 1'b0;
    vectors++;
    if (div !== 1'b1 || div_x !== 32'hFFFFFFFF || div_y !== 32'd16 || issue_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second_accept: got div=%b x=%h y=%h rdy=%b, required 1 ffffffff 00000010 0",
               div, div_x, div_y, issue_ready);
    end
    repeat (LAT - 1) @(negedge div_clk);
    d = divide(div_signed, div_x, div_y);
    div_s = d.lo; div_r = d.hi; div_complete = 1'b1;
    @(negedge div_clk);
    div_complete = 1'b0;
    vectors++;
    if (result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_rv: got %b, required 1", result_valid);
    end
    pop_compare("b2b_second");
    @(negedge div_clk);
  endtask

  task automatic test_flush();
    @(negedge div_clk);
    hi_we = 1'b1; hilo_wdata = 32'h1234;
    @(negedge div_clk);
    hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h5678;
    @(negedge div_clk);
    lo_we = 1'b0;
    vectors++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      miscompares++;
      $display("FAIL flush_preload: got hi=%h lo=%h, required 00001234 00005678", hi, lo);
    end
    issue_valid = 1'b1; op_signed = 1'b0; src_x = 32'd50; src_y = 32'd3;
    @(negedge div_clk);
    issue_valid = 1'b0;
    repeat (9) @(negedge div_clk);
    // flush coincides with a completion: flush must win
    flush = 1'b1; div_complete = 1'b1; div_s = 32'hDEAD; div_r = 32'hBEEF;
    @(negedge div_clk);
    flush = 1'b0; div_complete = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678 || div !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_abort: got rv=%b hi=%h lo=%h div=%b busy=%b, required 0 00001234 00005678 0 1",
               result_valid, hi, lo, div, busy);
    end
    @(negedge div_clk);
    vectors++;
    if (busy !== 1'b0 || issue_ready !== 1'b1 || result_valid !== 1'b0 || hi !== 32'h1234) begin
      miscompares++;
      $display("FAIL flush_idle: got busy=%b rdy=%b rv=%b hi=%h, required 0 1 0 00001234",
               busy, issue_ready, result_valid, hi);
    end
    issue_valid = 1'b1; flush = 1'b1;
    @(negedge div_clk);
    issue_valid = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || div !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_in_idle: got busy=%b div=%b, required 0 0", busy, div);
    end
  endtask

  task automatic test_timeout();
    @(negedge div_clk);
    issue_valid = 1'b1; op_signed = 1'b0; src_x = 32'd1; src_y = 32'd1;
    @(negedge div_clk);
    issue_valid = 1'b0;
    repeat (39) @(negedge div_clk);
    vectors++;
    if (div !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got div=%b to=%b, required 1 0", div, timeout_err);
    end
    @(negedge div_clk);
    vectors++;
    if (timeout_err !== 1'b1 || div !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got to=%b div=%b busy=%b rv=%b, required 1 0 1 0",
               timeout_err, div, busy, result_valid);
    end
    @(negedge div_clk);
    vectors++;
    if (busy !== 1'b0 || issue_ready !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_idle: got busy=%b rdy=%b to=%b, required 0 1 1", busy, issue_ready, timeout_err);
    end
  endtask

  task automatic test_capture_priority();
    @(negedge div_clk);
    issue_valid = 1'b1; op_signed = 1'b0; src_x = 32'd20; src_y = 32'd4;
    @(negedge div_clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge div_clk);
    hi_we = 1'b1; hilo_wdata = 32'h7777;
    @(negedge div_clk);
    hi_we = 1'b0;
    vectors++;
    if (hi !== 32'h7777 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL direct_in_run: got hi=%h busy=%b, required 00007777 1", hi, busy);
    end
    repeat (3) @(negedge div_clk);
    sb.push_back('{hi: 32'd9, lo: 32'd5});
    div_complete = 1'b1; div_s = 32'd5; div_r = 32'd9; lo_we = 1'b1; hilo_wdata = 32'hAAAA;
    @(negedge div_clk);
    div_complete = 1'b0; lo_we = 1'b0;
    vectors++;
    if (result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_rv: got %b, required 1", result_valid);
    end
    pop_compare("prio");
    @(negedge div_clk);
  endtask

  task automatic test_reset_mid_run();
    @(negedge div_clk);
    issue_valid = 1'b1; op_signed = 1'b1; src_x = 32'd8; src_y = 32'd2;
    @(negedge div_clk);
    issue_valid = 1'b0;
    repeat (5) @(negedge div_clk);
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (div !== 0 || busy !== 0 || issue_ready !== 1 || result_valid !== 0 || timeout_err !== 0 || div_signed !== 0) begin
      miscompares++;
      $display("FAIL midrst_ctl: got div=%b busy=%b rdy=%b rv=%b to=%b sgn=%b, required 0 0 1 0 0 0",
               div, busy, issue_ready, result_valid, timeout_err, div_signed);
    end
    vectors++;
    if (div_x !== 0 || div_y !== 0 || hi !== 0 || lo !== 0) begin
      miscompares++;
      $display("FAIL midrst_data: got x=%h y=%h hi=%h lo=%h, required all 0", div_x, div_y, hi, lo);
    end
    @(negedge div_clk);
    resetn = 1'b1;
    sb.push_back('{hi: 32'hFFFFFFFE, lo: 32'hFFFFFFF2});
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, "div_m100_7");
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_capture_priority();
    test_reset_mid_run();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
